// File: rtl/timer_sched_pkg.sv
// rtl/timer_sched_pkg.sv - shared state/mode encodings and default widths for timer_sched_ctrl
package timer_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam int DEF_N = 32;
  localparam int DEF_P = 16;

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - P-bit prescaler, ticks once every limit+1 enabled cycles
module timer_prescaler
  import timer_sched_pkg::*;
#(
  parameter int P = DEF_P
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [P-1:0] limit,
  output logic         tick
);

  logic [P-1:0] pre_cnt;

  assign tick = enable && (pre_cnt == limit);

  // Disabled cycles hold pre_cnt so a pause resumes exactly where it left off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
    end else if (clear || tick) begin
      pre_cnt <= '0;
    end else if (enable) begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_sched_ctrl.sv
// rtl/timer_sched_ctrl.sv - timer controller: run/pause/stop FSM, period compare; capture via TIMER_SCHED_CAPTURE_EN
module timer_sched_ctrl
  import timer_sched_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int P = DEF_P
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  input  logic         mode,
  input  logic [P-1:0] prescale,
  input  logic [N-1:0] period,
  output logic         count_enb,
  output logic [N-1:0] count,
  output logic         match,
  output logic         busy,
  output logic         done
`ifdef TIMER_SCHED_CAPTURE_EN
  ,
  input  logic         capture,
  output logic [N-1:0] cap_val
`endif
);

  state_t       state, state_nxt;
  logic         mode_l;
  logic [P-1:0] prescale_l;
  logic [N-1:0] period_l;
  logic [N-1:0] count_q;
  logic         run_en, tick, term;

  // Commands override counting in the cycle they arrive.
  assign run_en = (state == RUN) && !stop && !start;
  assign term   = tick && (count_q == period_l);

  timer_prescaler #(.P(P)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (stop || start),
    .enable (run_en),
    .limit  (prescale_l),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else if (start) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN: begin
          // A terminal tick in the pause cycle still completes; one-shot ends in DONE.
          if (term && (mode_l == MODE_ONESHOT)) state_nxt = DONE;
          else if (pause)                       state_nxt = PAUSE;
        end
        PAUSE:   if (!pause) state_nxt = RUN;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_l     <= MODE_ONESHOT;
      prescale_l <= '0;
      period_l   <= '0;
    end else if (start && !stop) begin
      mode_l     <= mode;
      prescale_l <= prescale;
      period_l   <= period;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      count_enb <= 1'b0;
      match     <= 1'b0;
    end else begin
      count_enb <= tick;
      match     <= term;
      if (stop || start)  count_q <= '0;
      else if (term)      count_q <= '0;
      else if (tick)      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;
  assign busy  = (state == RUN) || (state == PAUSE);
  assign done  = (state == DONE);

`ifdef TIMER_SCHED_CAPTURE_EN
  logic cap_s1, cap_s2, cap_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_s1  <= 1'b0;
      cap_s2  <= 1'b0;
      cap_d   <= 1'b0;
      cap_val <= '0;
    end else begin
      cap_s1 <= capture;
      cap_s2 <= cap_s1;
      cap_d  <= cap_s2;
      if (start)                cap_val <= '0;
      else if (cap_s2 && !cap_d) cap_val <= count_q;
    end
  end
`endif

endmodule

// File: tb/tb_timer_sched_ctrl.sv
// tb/tb_timer_sched_ctrl.sv - directed self-checking bench for timer_sched_ctrl
module tb_timer_sched_ctrl;
  import timer_sched_pkg::*;

  localparam int N = 32;
  localparam int P = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, stop, pause, mode;
  logic [P-1:0] prescale;
  logic [N-1:0] period;
  logic         count_enb, match, busy, done;
  logic [N-1:0] count;
`ifdef TIMER_SCHED_CAPTURE_EN
  logic         capture;
  logic [N-1:0] cap_val;
`endif

  int n_cmp = 0;
  int n_err = 0;

  timer_sched_ctrl #(.N(N), .P(P)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .mode      (mode),
    .prescale  (prescale),
    .period    (period),
    .count_enb (count_enb),
    .count     (count),
    .match     (match),
    .busy      (busy),
    .done      (done)
`ifdef TIMER_SCHED_CAPTURE_EN
    ,
    .capture   (capture),
    .cap_val   (cap_val)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input logic m, input logic [P-1:0] ps, input logic [N-1:0] per);
    start    = 1'b1;
    mode     = m;
    prescale = ps;
    period   = per;
    step();
    start    = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    mode = 1'b0; prescale = '0; period = '0;
`ifdef TIMER_SCHED_CAPTURE_EN
    capture = 1'b0;
`endif
    step();
    step();
    check_eq("rst_count", count, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_enb", count_enb, 0);
    reset = 1'b1;
    step();

    // periodic, prescale 0, period 3
    do_start(MODE_PERIODIC, 16'd0, 32'd3);
    check_eq("a_count0", count, 0);
    check_eq("a_busy", busy, 1);
    for (int i = 1; i <= 8; i++) begin
      step();
      check_eq("a_count", count, i % 4);
      check_eq("a_enb", count_enb, 1);
      check_eq("a_match", match, (i % 4) == 0);
    end
    check_eq("a_done", done, 0);

    // asynchronous reset between edges while running
    #2 reset = 1'b0;
    #1;
    check_eq("ar_count", count, 0);
    check_eq("ar_busy", busy, 0);
    check_eq("ar_enb", count_enb, 0);
    check_eq("ar_match", match, 0);
    reset = 1'b1;
    step();
    step();
    check_eq("ar_idle_count", count, 0);
    check_eq("ar_idle_enb", count_enb, 0);
    check_eq("ar_idle_busy", busy, 0);

    // one-shot, prescale 2, period 1
    do_start(MODE_ONESHOT, 16'd2, 32'd1);
    for (int i = 1; i <= 9; i++) begin
      step();
      check_eq("b_enb", count_enb, (i == 3) || (i == 6));
      check_eq("b_count", count, (i >= 3 && i < 6) ? 1 : 0);
      check_eq("b_match", match, i == 6);
      check_eq("b_done", done, i >= 6);
      check_eq("b_busy", busy, i < 6);
    end

    // periodic period 9, pause holds at 4
    do_start(MODE_PERIODIC, 16'd0, 32'd9);
    step(); step(); step();
    check_eq("c_count3", count, 3);
    pause = 1'b1;
    step();
    check_eq("c_count4", count, 4);
    for (int j = 0; j < 4; j++) begin
      step();
      check_eq("c_hold", count, 4);
      check_eq("c_hold_enb", count_enb, 0);
      check_eq("c_hold_busy", busy, 1);
    end
    pause = 1'b0;
    step();
    check_eq("c_resume0", count, 4);
    step();
    check_eq("c_resume5", count, 5);
    check_eq("c_resume_enb", count_enb, 1);
    step();
    check_eq("c_resume6", count, 6);
    step();
    check_eq("c_count7", count, 7);

    // start and stop together -> stop wins
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check_eq("d_stop_count", count, 0);
    check_eq("d_stop_busy", busy, 0);
    check_eq("d_stop_done", done, 0);
    step();
    check_eq("d_idle_count", count, 0);

    // restart at count 7 with a new period
    do_start(MODE_PERIODIC, 16'd0, 32'd9);
    for (int i = 0; i < 7; i++) step();
    check_eq("d_count7", count, 7);
    do_start(MODE_PERIODIC, 16'd0, 32'd2);
    check_eq("d_restart0", count, 0);
    check_eq("d_restart_enb", count_enb, 0);
    period = 32'd100;
    step();
    check_eq("d_restart1", count, 1);
    step();
    check_eq("d_restart2", count, 2);
    step();
    check_eq("d_newper_wrap", count, 0);
    check_eq("d_newper_match", match, 1);

    // period 0 matches every tick
    do_start(MODE_PERIODIC, 16'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("e_p0_match", match, 1);
      check_eq("e_p0_count", count, 0);
    end

`ifdef TIMER_SCHED_CAPTURE_EN
    do_start(MODE_PERIODIC, 16'd0, 32'd20);
    check_eq("f_cap_clr", cap_val, 0);
    for (int i = 0; i < 5; i++) step();
    check_eq("f_count5", count, 5);
    capture = 1'b1;
    step(); step(); step();
    check_eq("f_cap_val", cap_val, 7);
    capture = 1'b0;
`endif

    stop = 1'b1;
    step();
    stop = 1'b0;
    check_eq("g_stop_busy", busy, 0);
    check_eq("g_stop_count", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
